// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
// Provides default frame geometry, the receiver FSM state type and a 2-of-3 vote helper.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 8;
    localparam int unsigned DEFAULT_PRESCALE  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-window timing for the UART receiver: counts edge_cnt across each
// PRESCALE-cycle window and captures the bit value near the window centre.
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the
// centre instead of a single centre sample; window timing is the same either way.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_count_en,
    output logic o_bit,
    output logic o_win_end
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(PRESCALE / 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;

    // edge_cnt: free-runs 0..PRESCALE-1 while a frame is active, parked at 0 otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_count_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_s_early;
    logic r_s_mid;

    // Collect samples at MID-1 and MID, resolve the vote with the MID+1 sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_early <= 1'b0;
            r_s_mid   <= 1'b0;
            r_bit     <= 1'b0;
        end else if (i_count_en) begin
            if (r_cnt == CNT_MID - CNT_W'(1)) r_s_early <= i_rx;
            if (r_cnt == CNT_MID)             r_s_mid   <= i_rx;
            if (r_cnt == CNT_MID + CNT_W'(1)) r_bit     <= maj3(r_s_early, r_s_mid, i_rx);
        end
    end
`else
    // Single sample at the window centre
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit <= 1'b0;
        end else if (i_count_en && (r_cnt == CNT_MID)) begin
            r_bit <= i_rx;
        end
    end
`endif

    assign o_bit     = r_bit;
    assign o_win_end = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchronizer, frame FSM, LSB-first shifter and
// parity/stop checks. Results are registered one cycle after the stop window.
// Build option: UART_RX_MAJORITY_VOTE_EN (handled inside uart_rx_sampler).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int unsigned PRESCALE  = DEFAULT_PRESCALE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [DATA_SIZE-1:0] P_DATA,
    output logic                 Data_Valid,
    output logic                 PAR_ERR,
    output logic                 STP_ERR,
    output logic                 Busy
);

    localparam int unsigned BIT_W = $clog2(DATA_SIZE + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_d;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [DATA_SIZE-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_par_en;
    logic                 r_par_typ;
    logic                 r_par_bit;
    logic                 r_stop_bit;
    logic                 r_end;
    logic [DATA_SIZE-1:0] r_p_data;
    logic                 r_dv;
    logic                 r_par_err;
    logic                 r_stp_err;

    logic w_rx;
    logic w_bit;
    logic w_win_end;
    logic w_count_en;
    logic w_start_det;
    logic w_shift_en;
    logic w_par_cap;
    logic w_frame_end;
    logic w_par_exp;
    logic w_par_bad;
    logic w_stp_bad;
    logic w_good;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_rx       (w_rx),
        .i_count_en (w_count_en),
        .o_bit      (w_bit),
        .o_win_end  (w_win_end)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_d;
    end

    // Next state and datapath strobes; all bit decisions happen at window end
    always_comb begin
        w_state_d   = r_state;
        w_count_en  = (r_state != IDLE);
        w_start_det = 1'b0;
        w_shift_en  = 1'b0;
        w_par_cap   = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The detecting cycle is edge_cnt 0 of the start window
                if (!w_rx) begin
                    w_state_d   = START;
                    w_count_en  = 1'b1;
                    w_start_det = 1'b1;
                end
            end
            START: begin
                if (w_win_end) w_state_d = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_win_end) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_LAST) w_state_d = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_win_end) begin
                    w_par_cap = 1'b1;
                    w_state_d = STOP;
                end
            end
            STOP: begin
                if (w_win_end) begin
                    w_frame_end = 1'b1;
                    w_state_d   = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Frame datapath: per-frame config latch, shifter, captured parity/stop bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_end <= w_frame_end;
            if (w_start_det) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_bit_cnt <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[DATA_SIZE-1:1]};
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_par_cap)   r_par_bit  <= w_bit;
            if (w_frame_end) r_stop_bit <= w_bit;
        end
    end

    assign w_par_exp = (^r_shift) ^ r_par_typ;
    assign w_par_bad = r_par_en && (r_par_bit != w_par_exp);
    assign w_stp_bad = !r_stop_bit;
    assign w_good    = r_end && !w_par_bad && !w_stp_bad;

    // Registered frame result; P_DATA only moves on a good frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p_data  <= '0;
            r_dv      <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
        end else begin
            r_dv      <= w_good;
            r_par_err <= r_end && w_par_bad;
            r_stp_err <= r_end && w_stp_bad;
            if (w_good) r_p_data <= r_shift;
        end
    end

    assign P_DATA     = r_p_data;
    assign Data_Valid = r_dv;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;
    assign Busy       = (r_state != IDLE);

endmodule
